// File: rtl/sqr_share_arb_if.sv
// Requester-side bundle of the shared squarer arbiter.
// The requesters (master) present operands and collect results; the arbiter
// (slave) returns the one-hot grant and the registered result pulse.
interface sqr_share_arb_if;
    logic [3:0]  enable_mask;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [15:0] resp_data;

    modport master (
        output enable_mask,
        output req_valid,
        output req_data,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  enable_mask,
        input  req_valid,
        input  req_data,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/sqr_share_arb.sv
// Round-robin arbiter sharing one pipelined approximate FP16 squarer among the
// four distance lanes of the k-means engine. A tag pipeline that matches the
// squarer latency remembers who owns each in-flight result. It also remembers
// whether the operand had a zero exponent: such operands (zero and subnormals)
// are flushed to a +0 result, independent of what the squarer produces.
module sqr_share_arb #(
    parameter int SQ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    sqr_share_arb_if.slave bus,
    output logic [15:0] sq_in,
    input  logic [15:0] sq_out,
    output logic        busy,
    output logic [15:0] issue_count
);

    localparam int NREQ = 4;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
        logic       zero;
    } tag_t;

    // Decode a requester index into its one-hot lane bit.
    function automatic logic [NREQ-1:0] id_to_onehot(input logic [1:0] id);
        logic [NREQ-1:0] oh;
        case (id)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Zero-exponent operands (zero, subnormal) square to +0 in this engine.
    function automatic logic exp_is_zero(input logic [15:0] op);
        return (op[14:10] == 5'd0);
    endfunction

    // A square is never negative, so the sign bit is always forced clear.
    function automatic logic [15:0] clear_sign(input logic [15:0] val);
        return val & 16'h7FFF;
    endfunction

    logic [3:0]  eligible_s;
    logic [1:0]  probe_id_s;
    logic        found_s;
    logic [1:0]  grant_id_s;
    logic        grant_valid_s;
    logic [3:0]  grant_oh_s;
    logic [15:0] grant_op_s;

    logic [1:0]  last_grant_r;
    logic [15:0] issue_count_r;
    tag_t        tag_r [SQ_LAT];
    logic [3:0]  resp_valid_r;
    logic [15:0] resp_data_r;
    logic        tags_busy_s;

    // Round-robin search: probe from last_grant+1 upward, first eligible wins.
    always_comb begin
        eligible_s = bus.req_valid & bus.enable_mask;
        probe_id_s = 2'd0;
        found_s    = 1'b0;
        grant_id_s = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            probe_id_s = last_grant_r + 2'(k + 1);
            if (!found_s && eligible_s[probe_id_s]) begin
                found_s    = 1'b1;
                grant_id_s = probe_id_s;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Grant qualification (never during reset) and operand steering.
    always_comb begin
        grant_valid_s = found_s & ~rst;
        grant_oh_s    = 4'b0000;
        grant_op_s    = 16'h0000;
        if (grant_valid_s) begin
            grant_oh_s = id_to_onehot(grant_id_s);
            case (grant_id_s)
                2'd0:    grant_op_s = bus.req_data[15:0];
                2'd1:    grant_op_s = bus.req_data[31:16];
                2'd2:    grant_op_s = bus.req_data[47:32];
                2'd3:    grant_op_s = bus.req_data[63:48];
                default: grant_op_s = 16'h0000;
            endcase
        end else begin
            grant_oh_s = 4'b0000;
            grant_op_s = 16'h0000;
        end
    end

    assign bus.req_ready = grant_oh_s;
    assign sq_in         = grant_op_s;

    // Arbitration pointer and grant counter; both move only on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r  <= 2'd3;
            issue_count_r <= 16'h0000;
        end else if (grant_valid_s) begin
            last_grant_r  <= grant_id_s;
            issue_count_r <= issue_count_r + 16'd1;
        end else begin
            last_grant_r  <= last_grant_r;
            issue_count_r <= issue_count_r;
        end
    end

    // Tag pipeline tracking ownership of each result inside the squarer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SQ_LAT; s++) begin
                tag_r[s] <= '0;
            end
        end else begin
            tag_r[0] <= '{valid: grant_valid_s,
                          id:    grant_id_s,
                          zero:  exp_is_zero(grant_op_s)};
            for (int s = 1; s < SQ_LAT; s++) begin
                tag_r[s] <= tag_r[s-1];
            end
        end
    end

    // Result register: one-cycle pulse to the owning lane, data held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 4'b0000;
            resp_data_r  <= 16'h0000;
        end else if (tag_r[SQ_LAT-1].valid) begin
            resp_valid_r <= id_to_onehot(tag_r[SQ_LAT-1].id);
            resp_data_r  <= tag_r[SQ_LAT-1].zero ? 16'h0000 : clear_sign(sq_out);
        end else begin
            resp_valid_r <= 4'b0000;
            resp_data_r  <= resp_data_r;
        end
    end

    // Activity flag: anything in the squarer or a result currently pulsing.
    always_comb begin
        tags_busy_s = 1'b0;
        for (int s = 0; s < SQ_LAT; s++) begin
            tags_busy_s = tags_busy_s | tag_r[s].valid;
        end
        busy = tags_busy_s | (|resp_valid_r);
    end

    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign issue_count    = issue_count_r;

endmodule

// File: tb/tb_sqr_share_arb.sv
// Directed bench for sqr_share_arb: table-driven arbitration/response vectors
// on an SQ_LAT=1 instance plus hand-written reset, wrap and SQ_LAT=3 sequences.
module tb_sqr_share_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sqr_share_arb_if bus1();
    sqr_share_arb_if bus3();

    logic [15:0] sq_in1, sq_out1, issue1;
    logic        busy1;
    logic [15:0] sq_in3, sq_out3, issue3;
    logic        busy3;

    sqr_share_arb #(.SQ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .sq_in(sq_in1), .sq_out(sq_out1), .busy(busy1), .issue_count(issue1)
    );

    sqr_share_arb #(.SQ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .sq_in(sq_in3), .sq_out(sq_out3), .busy(busy3), .issue_count(issue3)
    );

    // Stand-in for the approximate squarer: any fixed scramble will do.
    function automatic logic [15:0] sq_fn(input logic [15:0] x);
        return {x[7:0], x[15:8]} ^ 16'hC3A5;
    endfunction

    // Expected delivered result for an operand.
    function automatic logic [15:0] exp_resp(input logic [15:0] op);
        logic [15:0] t;
        t = sq_fn(op);
        if (op[14:10] == 5'd0) return 16'h0000;
        else return {1'b0, t[14:0]};
    endfunction

    logic [15:0] sq1_q;
    logic [15:0] sq3_q [3];

    always_ff @(posedge clk) begin
        sq1_q    <= sq_fn(sq_in1);
        sq3_q[0] <= sq_fn(sq_in3);
        sq3_q[1] <= sq3_q[0];
        sq3_q[2] <= sq3_q[1];
    end
    assign sq_out1 = sq1_q;
    assign sq_out3 = sq3_q[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus1.enable_mask = 4'h0; bus1.req_valid = 4'h0; bus1.req_data = 64'h0;
        bus3.enable_mask = 4'h0; bus3.req_valid = 4'h0; bus3.req_data = 64'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  valid;
        logic [63:0] data;
        logic [3:0]  exp_ready;
        logic [15:0] exp_sq;
    } vec_t;

    vec_t vecs [14];
    localparam logic [63:0] D  = {16'hBC00, 16'h3C00, 16'h0000, 16'h4500};
    localparam logic [63:0] D2 = {16'hBC00, 16'h3C00, 16'h8001, 16'h4500};

    initial begin
        logic [3:0]  exp_rv;
        logic        exp_busy;
        logic [63:0] dat;

        vecs[0]  = '{4'hF, 4'b0100, D,  4'b0100, 16'h3C00};
        vecs[1]  = '{4'hF, 4'b0000, D,  4'b0000, 16'h0000};
        vecs[2]  = '{4'hF, 4'b1111, D,  4'b1000, 16'hBC00};
        vecs[3]  = '{4'hF, 4'b1111, D,  4'b0001, 16'h4500};
        vecs[4]  = '{4'hF, 4'b1111, D,  4'b0010, 16'h0000};
        vecs[5]  = '{4'hA, 4'b1111, D,  4'b1000, 16'hBC00};
        vecs[6]  = '{4'hA, 4'b1111, D,  4'b0010, 16'h0000};
        vecs[7]  = '{4'hA, 4'b1111, D,  4'b1000, 16'hBC00};
        vecs[8]  = '{4'h0, 4'b1111, D,  4'b0000, 16'h0000};
        vecs[9]  = '{4'hF, 4'b0101, D,  4'b0001, 16'h4500};
        vecs[10] = '{4'hF, 4'b0101, D,  4'b0100, 16'h3C00};
        vecs[11] = '{4'hF, 4'b0010, D2, 4'b0010, 16'h8001};
        vecs[12] = '{4'hF, 4'b0000, D2, 4'b0000, 16'h0000};
        vecs[13] = '{4'hF, 4'b0000, D2, 4'b0000, 16'h0000};

        // Reset with every requester asserting: nothing may be granted.
        rst = 1'b1;
        idle_inputs();
        bus1.enable_mask = 4'hF; bus1.req_valid = 4'hF; bus1.req_data = D;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_ready",      64'(bus1.req_ready),  64'(4'b0000));
        check("rst_sq_in",      64'(sq_in1),          64'(16'h0000));
        check("rst_resp_valid", 64'(bus1.resp_valid), 64'(4'b0000));
        check("rst_resp_data",  64'(bus1.resp_data),  64'(16'h0000));
        check("rst_busy",       64'(busy1),           64'(1'b0));
        check("rst_issue",      64'(issue1),          64'(16'h0000));
        @(posedge clk);
        #1 rst = 1'b0;

        // Table: one row per cycle; responses land two rows after the grant.
        for (int i = 0; i < 14; i++) begin
            bus1.enable_mask = vecs[i].mask;
            bus1.req_valid   = vecs[i].valid;
            bus1.req_data    = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 64'(bus1.req_ready), 64'(vecs[i].exp_ready));
            check($sformatf("vec%0d_sq_in", i), 64'(sq_in1), 64'(vecs[i].exp_sq));
            exp_rv   = (i >= 2) ? vecs[i-2].exp_ready : 4'b0000;
            exp_busy = (exp_rv != 4'b0000) || ((i >= 1) && (vecs[i-1].exp_ready != 4'b0000));
            check($sformatf("vec%0d_resp_valid", i), 64'(bus1.resp_valid), 64'(exp_rv));
            if (exp_rv != 4'b0000) begin
                check($sformatf("vec%0d_resp_data", i), 64'(bus1.resp_data),
                      64'(exp_resp(vecs[i-2].exp_sq)));
            end else begin
                n_checks = n_checks;
            end
            check($sformatf("vec%0d_busy", i), 64'(busy1), 64'(exp_busy));
            @(posedge clk);
            #1;
        end
        check("vec_issue_count", 64'(issue1), 64'(16'd10));

        // All four contending from reset: 0,1,2,3,0,... with in-order results.
        do_reset();
        dat = {16'h4C00, 16'h4800, 16'h4000, 16'h3E00};
        bus1.enable_mask = 4'hF; bus1.req_data = dat;
        for (int k = 0; k < 10; k++) begin
            bus1.req_valid = (k < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            check($sformatf("rr%0d_ready", k), 64'(bus1.req_ready),
                  64'((k < 8) ? 4'(4'b0001 << (k % 4)) : 4'b0000));
            if (k >= 2) begin
                check($sformatf("rr%0d_resp_valid", k), 64'(bus1.resp_valid),
                      64'(4'(4'b0001 << ((k - 2) % 4))));
                check($sformatf("rr%0d_resp_data", k), 64'(bus1.resp_data),
                      64'(exp_resp(16'(dat >> (16 * ((k - 2) % 4))))));
            end else begin
                check($sformatf("rr%0d_resp_valid", k), 64'(bus1.resp_valid), 64'(4'b0000));
            end
            @(posedge clk);
            #1;
        end
        check("rr_issue_count", 64'(issue1), 64'(16'd8));

        // Reset one cycle after a grant wipes the in-flight result.
        do_reset();
        bus1.enable_mask = 4'hF; bus1.req_valid = 4'b0001; bus1.req_data = D;
        @(negedge clk);
        check("mid_rst_grant", 64'(bus1.req_ready), 64'(4'b0001));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 64'(bus1.req_ready), 64'(4'b0000));
        @(posedge clk);
        #1 rst = 1'b0; bus1.req_valid = 4'b0000;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("mid_rst_resp%0d", j), 64'(bus1.resp_valid), 64'(4'b0000));
            if (j == 0) begin
                check("mid_rst_busy",  64'(busy1),  64'(1'b0));
                check("mid_rst_issue", 64'(issue1), 64'(16'h0000));
            end else begin
                n_checks = n_checks;
            end
            @(posedge clk);
            #1;
        end

        // Grant counter wrap: 65535 grants then one more.
        do_reset();
        bus1.enable_mask = 4'hF; bus1.req_valid = 4'b0001; bus1.req_data = D;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check("wrap_ffff", 64'(issue1), 64'(16'hFFFF));
        @(posedge clk);
        #1 bus1.req_valid = 4'b0000;
        @(negedge clk);
        check("wrap_zero", 64'(issue1), 64'(16'h0000));

        // SQ_LAT=3 instance: a grant at T answers at exactly T+4.
        do_reset();
        bus3.enable_mask = 4'hF; bus3.req_valid = 4'b0010;
        bus3.req_data = {16'h0000, 16'h0000, 16'h4800, 16'h0000};
        @(negedge clk);
        check("lat3_ready", 64'(bus3.req_ready), 64'(4'b0010));
        @(posedge clk);
        #1 bus3.req_valid = 4'b0000;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            check($sformatf("lat3_t%0d_resp_valid", j), 64'(bus3.resp_valid),
                  64'((j == 4) ? 4'b0010 : 4'b0000));
            if (j == 4) begin
                check("lat3_resp_data", 64'(bus3.resp_data), 64'(exp_resp(16'h4800)));
            end else begin
                check($sformatf("lat3_t%0d_busy", j), 64'(busy3), 64'((j < 4) ? 1'b1 : 1'b0));
            end
            @(posedge clk);
            #1;
        end
        check("lat3_issue", 64'(issue3), 64'(16'd1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
